// File: rtl/i4_recon_collect.sv
// Collects sixteen reconstructed 4x4 luma blocks into a 16x16 macroblock, then
// drains it row by row and publishes the bottom row / right column as context.
module i4_recon_collect (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         load,
    output logic         load_ready,
    input  logic [4:0]   i4,
    input  logic [127:0] Yin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_row,
    output logic [127:0] out_data,
    output logic [127:0] top_next,
    output logic [127:0] left_next,
    output logic         ctx_valid
);

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] buf_q [16];
    logic [127:0] buf_d [16];
    logic [15:0]  mask_q, mask_d;
    logic [3:0]   row_q, row_d;
    logic [127:0] top_q, top_d;
    logic [127:0] left_q, left_d;
    logic         ctx_q, ctx_d;
    logic         accept;
    logic         complete;

    // Outputs come only from registers, so Yin/load never reach out_data/out_valid.
    assign load_ready = (state_q == COLLECT);
    assign out_valid  = (state_q == DRAIN);
    assign out_row    = row_q;
    assign out_data   = buf_q[row_q];
    assign top_next   = top_q;
    assign left_next  = left_q;
    assign ctx_valid  = ctx_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        mask_d   = mask_q;
        row_d    = row_q;
        top_d    = top_q;
        left_d   = left_q;
        ctx_d    = 1'b0;
        complete = 1'b0;
        for (int i = 0; i < 16; i++) begin
            buf_d[i] = buf_q[i];
        end
        accept = load && (state_q == COLLECT) && !i4[4] && !flush;

        if (flush) begin
            state_d = COLLECT;
            mask_d  = '0;
            row_d   = '0;
        end else if (state_q == COLLECT) begin
            if (accept) begin
                // Block (bx,by) row r lands at buffer row 4*by+r, pixels 4*bx..4*bx+3.
                for (int r = 0; r < 4; r++) begin
                    buf_d[{i4[3:2], 2'(r)}][{i4[1:0], 5'd0} +: 32] = Yin[32*r +: 32];
                end
                mask_d   = mask_q | (16'd1 << i4[3:0]);
                complete = &mask_d;
            end
            if (complete) begin
                // Context is taken from the post-write buffer so the final block is included.
                state_d = DRAIN;
                row_d   = '0;
                ctx_d   = 1'b1;
                top_d   = buf_d[15];
                for (int y = 0; y < 16; y++) begin
                    left_d[8*y +: 8] = buf_d[y][127:120];
                end
            end
        end else if (out_ready) begin
            if (row_q == 4'd15) begin
                state_d = COLLECT;
                mask_d  = '0;
                row_d   = '0;
            end else begin
                row_d = row_q + 4'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            mask_q  <= '0;
            row_q   <= '0;
            top_q   <= '0;
            left_q  <= '0;
            ctx_q   <= 1'b0;
            // NOTE: the pixel buffer must read back as zero after reset, so it is a reset register file, not a RAM.
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            row_q   <= row_d;
            top_q   <= top_d;
            left_q  <= left_d;
            ctx_q   <= ctx_d;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

endmodule

// File: tb/tb_i4_recon_collect.sv
// Scoreboard bench for i4_recon_collect: a pixel model predicts each macroblock
// and queues expected rows, which are popped as the DUT hands them over.
module tb_i4_recon_collect;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         load = 1'b0;
    logic         out_ready = 1'b1;
    logic [4:0]   i4 = '0;
    logic [127:0] Yin = '0;
    logic         load_ready, out_valid, ctx_valid;
    logic [3:0]   out_row;
    logic [127:0] out_data, top_next, left_next;

    localparam logic [127:0] GOLD_ROW0 = 128'h03030303_02020202_01010101_00000000;
    localparam logic [127:0] GOLD_TOP  = 128'h0f0f0f0f_0e0e0e0e_0d0d0d0d_0c0c0c0c;
    localparam logic [127:0] GOLD_LEFT = 128'h0f0f0f0f_0b0b0b0b_07070707_03030303;

    typedef struct packed {
        logic [3:0]   row;
        logic [127:0] data;
    } row_t;

    row_t         sb_q[$];
    logic [127:0] m_buf [16];
    logic [15:0]  m_mask;
    logic [127:0] m_top, m_left;
    int           vectors = 0;
    int           miscompares = 0;

    always #5 clk = ~clk;

    i4_recon_collect dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .load       (load),
        .load_ready (load_ready),
        .i4         (i4),
        .Yin        (Yin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .out_data   (out_data),
        .top_next   (top_next),
        .left_next  (left_next),
        .ctx_valid  (ctx_valid)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_buf[i] = '0;
        m_mask = '0;
        m_top  = '0;
        m_left = '0;
        sb_q.delete();
    endtask

    // Called at a negedge; returns at the following negedge with load released.
    task automatic load_blk(input logic [4:0] idx, input logic [7:0] val);
        bit done_now = 1'b0;
        load = 1'b1;
        i4   = idx;
        Yin  = {16{val}};
        if (!idx[4]) begin
            for (int r = 0; r < 4; r++) begin
                m_buf[{idx[3:2], 2'(r)}][{idx[1:0], 5'd0} +: 32] = {4{val}};
            end
            m_mask = m_mask | (16'd1 << idx[3:0]);
            if (&m_mask) begin
                done_now = 1'b1;
                for (int y = 0; y < 16; y++) begin
                    sb_q.push_back('{row: 4'(y), data: m_buf[y]});
                    m_left[8*y +: 8] = m_buf[y][127:120];
                end
                m_top  = m_buf[15];
                m_mask = '0;
            end
        end
        @(negedge clk);
        load = 1'b0;
        check("load_ready", {127'd0, load_ready}, {127'd0, !done_now});
        check("out_valid",  {127'd0, out_valid},  {127'd0, done_now});
        check("ctx_valid",  {127'd0, ctx_valid},  {127'd0, done_now});
        if (done_now) begin
            check("out_row0",  {124'd0, out_row}, 128'd0);
            check("top_next",  top_next,  m_top);
            check("left_next", left_next, m_left);
        end
    endtask

    task automatic drain(input int stall_row, input int stall_n, input int flush_row);
        bit   done = 1'b0;
        int   guard = 0;
        bit   last;
        row_t e;
        out_ready = 1'b1;
        while (!done && guard < 200) begin
            guard++;
            if (!out_valid || sb_q.size() == 0) begin
                check("drain_valid", {127'd0, out_valid}, {127'd0, sb_q.size() != 0});
                done = 1'b1;
            end else begin
                e = sb_q[0];
                check("out_row",  {124'd0, out_row}, {124'd0, e.row});
                check("out_data", out_data, e.data);
                if (int'(out_row) == flush_row) begin
                    flush = 1'b1;
                    @(negedge clk);
                    flush = 1'b0;
                    check("flush_valid", {127'd0, out_valid},  128'd0);
                    check("flush_ready", {127'd0, load_ready}, 128'd1);
                    check("flush_ctx",   {127'd0, ctx_valid},  128'd0);
                    check("flush_row",   {124'd0, out_row},    128'd0);
                    check("flush_top",   top_next,  m_top);
                    check("flush_left",  left_next, m_left);
                    sb_q.delete();
                    done = 1'b1;
                end else if (int'(out_row) == stall_row && stall_n > 0) begin
                    // A load while draining must not touch the buffer (block 5 covers row 7).
                    out_ready = 1'b0;
                    load      = 1'b1;
                    i4        = 5'd5;
                    Yin       = {16{8'hee}};
                    repeat (stall_n) begin
                        @(negedge clk);
                        check("stall_row",   {124'd0, out_row},    {124'd0, e.row});
                        check("stall_data",  out_data, e.data);
                        check("stall_ready", {127'd0, load_ready}, 128'd0);
                        check("stall_valid", {127'd0, out_valid},  128'd1);
                    end
                    load      = 1'b0;
                    out_ready = 1'b1;
                    stall_n   = 0;
                end else begin
                    void'(sb_q.pop_front());
                    last = (out_row == 4'd15);
                    @(negedge clk);
                    check("drain_ctx", {127'd0, ctx_valid}, 128'd0);
                    if (last) begin
                        check("end_valid", {127'd0, out_valid},  128'd0);
                        check("end_ready", {127'd0, load_ready}, 128'd1);
                        done = 1'b1;
                    end
                end
            end
        end
        if (!done) check("drain_timeout", 128'd1, 128'd0);
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_valid", {127'd0, out_valid},  128'd0);
        check("rst_ready", {127'd0, load_ready}, 128'd1);
        check("rst_ctx",   {127'd0, ctx_valid},  128'd0);
        check("rst_row",   {124'd0, out_row},    128'd0);
        check("rst_data",  out_data,  128'd0);
        check("rst_top",   top_next,  128'd0);
        check("rst_left",  left_next, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Raster fill with a 5-cycle stall at row 7.
        for (int k = 0; k < 16; k++) load_blk(5'(k), 8'(k));
        check("gold_row0", out_data,  GOLD_ROW0);
        check("gold_top",  top_next,  GOLD_TOP);
        check("gold_left", left_next, GOLD_LEFT);
        drain(7, 5, -1);

        // Overwrite of block 5 and an invalid index in the middle of the fill.
        load_blk(5'd0, 8'h00);
        load_blk(5'd5, 8'haa);
        load_blk(5'd5, 8'hbb);
        load_blk(5'h10, 8'h77);
        for (int k = 1; k < 16; k++) begin
            if (k != 5) load_blk(5'(k), 8'(k + 8'h40));
        end
        drain(-1, 0, -1);

        // Flush during drain at row 3, then a fresh macroblock from row 0.
        for (int k = 0; k < 16; k++) load_blk(5'(k), 8'(k + 8'h20));
        drain(-1, 0, 3);
        @(negedge clk);
        check("post_flush_ctx", {127'd0, ctx_valid}, 128'd0);
        for (int k = 0; k < 16; k++) load_blk(5'(k), 8'(k + 8'h60));
        drain(-1, 0, -1);

        // Reset after ten blocks abandons the partial macroblock.
        for (int k = 0; k < 10; k++) load_blk(5'(k), 8'(k + 8'h80));
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_valid", {127'd0, out_valid},  128'd0);
        check("arst_ready", {127'd0, load_ready}, 128'd1);
        check("arst_data",  out_data,  128'd0);
        check("arst_top",   top_next,  128'd0);
        check("arst_left",  left_next, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 10; k < 16; k++) load_blk(5'(k), 8'(k + 8'h90));
        for (int k = 0; k < 10; k++)  load_blk(5'(k), 8'(k + 8'h90));
        drain(-1, 0, -1);

        // Reverse order: completion lands on index 0.
        for (int k = 15; k >= 0; k--) load_blk(5'(k), 8'(k));
        check("rev_row0", out_data,  GOLD_ROW0);
        check("rev_top",  top_next,  GOLD_TOP);
        check("rev_left", left_next, GOLD_LEFT);
        drain(-1, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i4_recon_collect.md
I4_RECON_COLLECT -- requirements
Module: I4ReconCollect

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: flush  input  1  synchronous abort of the current macroblock.
REQ-004 SHALL have port: load  input  1  a reconstructed 4x4 block is present on Yin.
REQ-005 SHALL have port: load_ready  output  1  block collector can accept a block.
REQ-006 SHALL have port: i4  input  5  4x4 block index; bx = i4[1:0], by = i4[3:2]; i4[4] set means invalid.
REQ-007 SHALL have port: Yin  input  128  4x4 block; row r = Yin[32r+31:32r], pixel c = byte c of that row word.
REQ-008 SHALL have port: out_valid  output  1  a 16-pixel macroblock row is on out_data.
REQ-009 SHALL have port: out_ready  input  1  downstream accepts the row.
REQ-010 SHALL have port: out_row  output  4  index (0..15) of the row on out_data.
REQ-011 SHALL have port: out_data  output  128  macroblock row; pixel x = out_data[8x+7:8x].
REQ-012 SHALL have port: top_next  output  128  macroblock row 15, same pixel order as out_data.
REQ-013 SHALL have port: left_next  output  128  macroblock column 15; row y = left_next[8y+7:8y].
REQ-014 SHALL have port: ctx_valid  output  1  one-cycle pulse: top_next/left_next updated.

Function
REQ-015 SHALL hold a 16x16 byte buffer, a 16-bit written mask, and a 4-bit drain row counter.
REQ-016 SHALL implement states COLLECT and DRAIN; load_ready = 1 only in COLLECT.
REQ-017 SHALL accept a block when load && load_ready && !i4[4] && !flush.
- Effect: Yin row r, pixel c goes to buffer(4*by+r, 4*bx+c).
- Effect: mask bit i4[3:0] is set.
REQ-018 SHALL ignore load when i4[4] = 1, when in DRAIN, or when flush = 1; none of these changes the buffer or the mask.
REQ-019 SHALL overwrite the buffer data when a block index that is already written is loaded again; the mask is unchanged.
REQ-020 SHALL accept blocks in any order.
REQ-021 SHALL complete the macroblock when an accepted block makes the mask all ones, evaluated on the post-write mask.
REQ-022 On completion in cycle N, SHALL in cycle N+1:
- enter DRAIN;
- assert out_valid with out_row = 0;
- load top_next = buffer row 15 and left_next = buffer column 15, including the block written in cycle N;
- pulse ctx_valid high for exactly that cycle.
REQ-023 SHALL drive out_data = buffer row out_row whenever out_valid = 1, stable until accepted.
REQ-024 SHALL advance out_row by 1 on each cycle with out_valid && out_ready.
REQ-025 SHALL handle acceptance of row 15 as follows:
- clear the mask and out_row;
- deassert out_valid and return to COLLECT on the next cycle;
- load_ready = 1 from that cycle.
REQ-026 SHALL keep out_valid asserted with out_row unchanged while out_ready = 0; there is no timeout.
REQ-027 SHALL give flush precedence over load and over the drain handshake. In either state, flush SHALL:
- clear the mask and out_row;
- deassert out_valid;
- enter COLLECT on the next cycle;
- leave the buffer contents, top_next and left_next unchanged;
- produce no ctx_valid.
REQ-028 SHALL hold top_next and left_next until the next completion.
REQ-029 SHALL have zero combinational path from Yin or load to out_data or out_valid.

Reset
REQ-030 SHALL, while rst_n = 0, asynchronously clear to zero:
- buffer, mask, out_row;
- top_next, left_next;
- out_valid, ctx_valid.
The state SHALL be COLLECT, so load_ready = 1.
REQ-031 SHALL abandon a partial or draining macroblock on reset; there SHALL be no output after release until 16 new blocks complete.

Verification
REQ-032 Raster fill: load i4 = 0..15, block k bytes all = k, out_ready = 1.
- ctx_valid pulses one cycle after the i4 = 15 load.
- 16 rows, one per cycle; row 0 = bytes {0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3}.
- top_next = row 15 = bytes {12,12,12,12,13,13,13,13,14,14,14,14,15,15,15,15}.
- left_next = all 0x03..0x0F pattern; column 15 = byte 3, 7, 11, 15 per 4-row group.
REQ-033 Backpressure: hold out_ready = 0 for 5 cycles at row 7 -> out_row = 7 and out_data stable; load_ready = 0 throughout.
REQ-034 Overwrite and invalid:
- Load i4 = 5 twice (0xAA, then 0xBB) -> buffer holds 0xBB.
- Load i4 = 0x10 -> ignored; completion still requires 16 distinct indices.
REQ-035 Flush mid-drain: flush at row 3 -> next cycle out_valid = 0, load_ready = 1, no ctx_valid; a fresh 16 loads then restart from row 0.
REQ-036 Reset mid-collect: assert rst_n = 0 after 10 blocks -> all outputs 0; after release, 16 further loads are needed before out_valid.
REQ-037 Reverse order: load i4 = 15 down to 0 -> completion fires on the i4 = 0 load; out_data matches raster-fill golden data.
